approx_product_error_monitor: RTL and testbench



---
 rtl/approx_product_error_monitor_pkg.sv | 18 +
 rtl/approx_product_error_monitor_abs_diff.sv | 14 +
 rtl/approx_product_error_monitor.sv | 115 +++++++++++
 tb/tb_approx_product_error_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_product_error_monitor_pkg.sv
// Shared types and sizing helpers for the approximate-product error monitors.
package approx_pkg;

  localparam int unsigned DEFAULT_PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Width needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/approx_product_error_monitor_abs_diff.sv
// Unsigned absolute difference |a - b| at full width, without wrap-around.
module abs_diff_unsigned #(
  parameter int unsigned PROD_W = 64
) (
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  output logic [PROD_W-1:0] diff
);

  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/approx_product_error_monitor.sv
// Windowed error statistics (count, sum, max of |approx - exact|) for approximate multipliers.
module approx_product_error_monitor
  import approx_pkg::*;
#(
  parameter int unsigned PROD_W    = DEFAULT_PROD_W,
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned CNT_W     = cnt_width(N_SAMPLES),
  parameter int unsigned SUM_W     = PROD_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] approx_prod,
  input  logic [PROD_W-1:0] exact_prod,
  output logic              done,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [SUM_W-1:0]  err_sum,
  output logic [PROD_W-1:0] err_max
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0] abs_q;
  logic              v1_q;
  logic [PROD_W-1:0] abs_d;
  logic [CNT_W-1:0]  samp_q, samp_d;
  logic [CNT_W-1:0]  errc_q, errc_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [PROD_W-1:0] max_q, max_d;

  logic accept;
  logic clear;
  logic last_accept;

  abs_diff_unsigned #(
    .PROD_W(PROD_W)
  ) u_abs (
    .a   (approx_prod),
    .b   (exact_prod),
    .diff(abs_d)
  );

  assign in_ready    = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign accept      = in_valid && in_ready;
  assign clear       = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_accept = accept && (acc_q == CNT_W'(N_SAMPLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (last_accept) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    samp_d = samp_q;
    errc_d = errc_q;
    sum_d  = sum_q;
    max_d  = max_q;
    if (accept) acc_d = acc_q + CNT_W'(1);
    // Stage 2 folds the registered difference in, one cycle after acceptance.
    if (v1_q) begin
      samp_d = samp_q + CNT_W'(1);
      errc_d = errc_q + CNT_W'(abs_q != '0);
      sum_d  = sum_q + SUM_W'(abs_q);
      if (abs_q > max_q) max_d = abs_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      abs_q   <= '0;
      v1_q    <= 1'b0;
      samp_q  <= '0;
      errc_q  <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else if (clear) begin
      state_q <= state_d;
      acc_q   <= '0;
      abs_q   <= '0;
      v1_q    <= 1'b0;
      samp_q  <= '0;
      errc_q  <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      v1_q    <= accept;
      if (accept) abs_q <= abs_d;
      samp_q  <= samp_d;
      errc_q  <= errc_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign sample_count = samp_q;
  assign err_count    = errc_q;
  assign err_sum      = sum_q;
  assign err_max      = max_q;

endmodule

// File: tb/tb_approx_product_error_monitor.sv
// Directed bench for approx_product_error_monitor with a 4-sample window.
module tb_approx_product_error_monitor;

  localparam int unsigned PROD_W = 64;
  localparam int unsigned N      = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SUM_W  = 67;
  localparam logic [63:0] E      = 64'd495443753321;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] approx_prod = '0;
  logic [PROD_W-1:0] exact_prod = '0;
  logic              done;
  logic [CNT_W-1:0]  sample_count;
  logic [CNT_W-1:0]  err_count;
  logic [SUM_W-1:0]  err_sum;
  logic [PROD_W-1:0] err_max;

  int pass_cnt = 0;
  int total_cnt = 0;

  approx_product_error_monitor #(
    .PROD_W   (PROD_W),
    .N_SAMPLES(N),
    .CNT_W    (CNT_W),
    .SUM_W    (SUM_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .approx_prod (approx_prod),
    .exact_prod  (exact_prod),
    .done        (done),
    .sample_count(sample_count),
    .err_count   (err_count),
    .err_sum     (err_sum),
    .err_max     (err_max)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_stats(input string tag, input int unsigned sc, input int unsigned ec,
                           input logic [127:0] sum, input logic [127:0] mx);
    chk({tag, "_samples"}, 128'(sample_count), 128'(sc));
    chk({tag, "_errcnt"},  128'(err_count),    128'(ec));
    chk({tag, "_errsum"},  128'(err_sum),      sum);
    chk({tag, "_errmax"},  128'(err_max),      mx);
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] e);
    in_valid    = v;
    approx_prod = a;
    exact_prod  = e;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 128'(in_ready), 128'(0));
    chk("rst_done",  128'(done),     128'(0));
    chk_stats("rst", 0, 0, 128'(0), 128'(0));
    drive(1'b1, E + 64'd9, E);
    tick();
    chk("idle_noaccept", 128'(in_ready), 128'(0));

    // 1: four exact matches
    drive(1'b0, '0, '0);
    do_start();
    chk("t1_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, E, E);
      tick();
    end
    drive(1'b0, '0, '0);
    chk("t1_drain_ready", 128'(in_ready), 128'(0));
    chk("t1_drain_done",  128'(done),     128'(0));
    tick();
    chk("t1_done", 128'(done), 128'(1));
    chk_stats("t1", 4, 0, 128'(0), 128'(0));

    // 2: errors 0, -1000, +5, +1000 with latency checks
    do_start();
    chk("t2_cleared_done", 128'(done), 128'(0));
    drive(1'b1, E, E);
    tick();
    chk("t2_lat0", 128'(sample_count), 128'(0));
    drive(1'b1, E - 64'd1000, E);
    tick();
    chk("t2_lat1", 128'(sample_count), 128'(1));
    chk("t2_lat1_err", 128'(err_count), 128'(0));
    drive(1'b1, E + 64'd5, E);
    tick();
    chk("t2_lat2_sum", 128'(err_sum), 128'(1000));
    drive(1'b1, E + 64'd1000, E);
    tick();
    drive(1'b0, '0, '0);
    chk("t2_drain_ready", 128'(in_ready), 128'(0));
    tick();
    chk("t2_done", 128'(done), 128'(1));
    chk_stats("t2", 4, 3, 128'(2005), 128'(1000));

    // 3: worst-case difference, sum must not wrap
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, '0, '1);
      tick();
    end
    drive(1'b0, '0, '0);
    tick();
    chk("t3_done", 128'(done), 128'(1));
    chk_stats("t3", 4, 4, 128'h3_FFFF_FFFF_FFFF_FFFC, 128'hFFFF_FFFF_FFFF_FFFF);

    // 4: gappy valid 1,0,1,0,0,1,1 with start pulsed mid-window
    do_start();
    drive(1'b1, E + 64'd1, E);        tick();
    drive(1'b0, E + 64'd100000, E);   tick();
    drive(1'b1, E + 64'd2, E);        tick();
    drive(1'b0, E + 64'd100000, E);   start = 1'b1; tick(); start = 1'b0;
    chk("t4_start_ignored", 128'(in_ready), 128'(1));
    drive(1'b0, E + 64'd100000, E);   tick();
    chk("t4_mid_samples", 128'(sample_count), 128'(2));
    drive(1'b1, E + 64'd3, E);        tick();
    drive(1'b1, E + 64'd4, E);        tick();
    chk("t4_drain_ready", 128'(in_ready), 128'(0));
    drive(1'b1, E + 64'd100000, E);   tick();
    chk("t4_done", 128'(done), 128'(1));
    chk("t4_done_ready", 128'(in_ready), 128'(0));
    chk_stats("t4", 4, 4, 128'(10), 128'(4));
    tick();
    chk("t4_frozen_done", 128'(done), 128'(1));
    chk_stats("t4_frozen", 4, 4, 128'(10), 128'(4));

    // 5: reset mid-window discards partial data
    drive(1'b0, '0, '0);
    do_start();
    drive(1'b1, E + 64'd50, E); tick();
    drive(1'b1, E - 64'd50, E); tick();
    drive(1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ready", 128'(in_ready), 128'(0));
    chk("t5_rst_done",  128'(done),     128'(0));
    chk_stats("t5_rst", 0, 0, 128'(0), 128'(0));
    tick();
    chk("t5_no_late", 128'(sample_count), 128'(0));
    do_start();
    drive(1'b1, E - 64'd7, E); tick();
    drive(1'b1, E, E);         tick();
    drive(1'b1, E, E);         tick();
    drive(1'b1, E + 64'd3, E); tick();
    drive(1'b0, '0, '0);
    tick();
    chk("t5_done", 128'(done), 128'(1));
    chk_stats("t5", 4, 2, 128'(10), 128'(7));

    // 6: start from DONE with valid high does not accept on the start edge
    drive(1'b1, E + 64'd999, E);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_done_drop", 128'(done), 128'(0));
    chk("t6_ready", 128'(in_ready), 128'(1));
    chk_stats("t6_clr", 0, 0, 128'(0), 128'(0));
    drive(1'b1, E + 64'd6, E);
    tick();
    chk("t6_lat", 128'(sample_count), 128'(0));
    drive(1'b0, '0, '0);
    tick();
    chk_stats("t6", 1, 1, 128'(6), 128'(6));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
